// File: rtl/mips_alu_muldiv.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus iterative unsigned
// multiply (shift-add) and restoring divide writing the HI/LO registers.
module mips_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             valid_out,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;
    localparam int         CW      = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_valid;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ovf_add;
    logic               w_ovf_sub;
    logic               w_slt;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_ovf;
    logic [2*WIDTH-1:0] w_acc_sum;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;

    assign busy      = (r_state != S_IDLE);
    assign ready_out = !busy;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign valid_out = r_valid;
    assign hi        = r_hi;
    assign lo        = r_lo;

    assign w_accept  = valid_in && (r_state == S_IDLE);
    assign w_last    = (r_count == CW'(WIDTH - 1));

    // Single-cycle ALU; SLT uses sign-of-difference corrected by overflow.
    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    assign w_slt     = w_diff[WIDTH-1] ^ w_ovf_sub;

    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (op)
            OP_AND: w_alu_result = a & b;
            OP_OR:  w_alu_result = a | b;
            OP_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = w_ovf_add;
            end
            OP_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = w_ovf_sub;
            end
            OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_alu_result = '0;
        endcase
    end

    // Multiply step: conditionally add the shifted multiplicand.
    assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Restoring divide step; a zero divisor always "fits", giving all-ones
    // quotient and the dividend as remainder.
    assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_divisor};
    assign w_qbit      = !w_rem_diff[WIDTH];
    assign w_rem_next  = w_qbit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_qbit};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && op == OP_MULU) begin
                    w_state_next = S_MUL;
                end else if (w_accept && op == OP_DIVU) begin
                    w_state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MULU) begin
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_count  <= '0;
                        end else if (op == OP_DIVU) begin
                            r_divisor <= b;
                            r_quot    <= a;
                            r_rem     <= '0;
                            r_count   <= '0;
                        end else begin
                            r_result <= w_alu_result;
                            r_zero   <= (w_alu_result == '0);
                            r_ovf    <= w_alu_ovf;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        r_hi     <= w_acc_sum[2*WIDTH-1:WIDTH];
                        r_lo     <= w_acc_sum[WIDTH-1:0];
                        r_result <= w_acc_sum[WIDTH-1:0];
                        r_zero   <= (w_acc_sum[WIDTH-1:0] == '0);
                        r_ovf    <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_hi     <= w_rem_next;
                        r_lo     <= w_quot_next;
                        r_result <= w_quot_next;
                        r_zero   <= (w_quot_next == '0);
                        r_ovf    <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed bench for mips_alu_muldiv at WIDTH=32: ALU ops, SLT extremes,
// MULTU/DIVU latency and results, back-to-back issue and mid-run reset.
module tb_mips_alu_muldiv;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_RSV  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        valid_out;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mips_alu_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .valid_out (valid_out),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one single-cycle op; returns 1 ns after the accepting edge.
    task automatic alu_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ovf);
        op = o; a = x; b = y; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        $display("op %b a=%08h b=%08h -> result=%08h zero=%0b ovf=%0b valid=%0b",
                 o, x, y, result, zero, ovf, valid_out);
        check({tag, ".valid"}, 32'(valid_out), 32'd1);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    // Issue MULTU/DIVU and wait (bounded) for valid_out; operands are
    // scrambled after accept and an optional valid_in poke is made mid-run.
    task automatic multi_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            input bit poke, output int lat, output int bsy, output int vbad);
        op = o; a = x; b = y; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        a = 32'h1234_5678;
        b = 32'h0000_0003;
        lat = 0; bsy = 0; vbad = 0;
        while (lat < 100) begin
            if (busy) bsy++;
            if (valid_out) vbad++;
            if (poke && lat == 5) begin
                op = OP_ADD; a = 32'd1; b = 32'd1; valid_in = 1'b1;
            end
            if (poke && lat == 6) valid_in = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (valid_out) break;
        end
        valid_in = 1'b0;
        $display("op %b a=%08h b=%08h -> hi=%08h lo=%08h result=%08h latency=%0d",
                 o, x, y, hi, lo, result, lat);
    endtask

    int lat, bsy, vbad, vseen;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.result", result, 32'd0);
        check("rst.flags", {28'd0, zero, ovf, valid_out, busy}, 32'd0);
        check("rst.ready", 32'(ready_out), 32'd1);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        rst = 1'b0;

        alu_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("add_ovf.drop", 32'(valid_out), 32'd0);
        alu_op("sub_zero", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        alu_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        alu_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0);
        alu_op("or", OP_OR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0);
        alu_op("slt_min", OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);
        alu_op("slt_max", OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        alu_op("slt_eq", OP_SLT, 32'd42, 32'd42, 32'd0, 1'b1, 1'b0);
        alu_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);

        multi_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bsy, vbad);
        check("mul.latency", 32'(lat), 32'd32);
        check("mul.busy_cycles", 32'(bsy), 32'd32);
        check("mul.valid_while_busy", 32'(vbad), 32'd0);
        check("mul.hi", hi, 32'hFFFF_FFFE);
        check("mul.lo", lo, 32'h0000_0001);
        check("mul.result", result, 32'h0000_0001);
        check("mul.busy_done", 32'(busy), 32'd0);
        check("mul.ready_done", 32'(ready_out), 32'd1);

        multi_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, bsy, vbad);
        check("div.latency", 32'(lat), 32'd32);
        check("div.lo", lo, 32'd14);
        check("div.hi", hi, 32'd2);
        check("div.result", result, 32'd14);

        multi_op(OP_DIVU, 32'd9, 32'd0, 1'b0, lat, bsy, vbad);
        check("div0.latency", 32'(lat), 32'd32);
        check("div0.lo", lo, 32'hFFFF_FFFF);
        check("div0.hi", hi, 32'd9);

        alu_op("rsv", OP_RSV, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0);
        check("rsv.hi", hi, 32'd9);
        check("rsv.lo", lo, 32'hFFFF_FFFF);

        op = OP_MULU; a = 32'hFFFF_FFFF; b = 32'd2; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.ready", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        vseen = 0;
        for (int i = 0; i < 3; i++) begin
            if (valid_out) vseen++;
            @(posedge clk); #1;
        end
        check("abort.no_valid", 32'(vseen), 32'd0);
        $display("reset abort during MULTU -> hi=%08h lo=%08h busy=%0b", hi, lo, busy);

        multi_op(OP_DIVU, 32'd8, 32'd2, 1'b0, lat, bsy, vbad);
        check("div8.latency", 32'(lat), 32'd32);
        check("div8.lo", lo, 32'd4);
        check("div8.hi", hi, 32'd0);

        multi_op(OP_MULU, 32'd3, 32'd5, 1'b0, lat, bsy, vbad);
        check("b2b.mul_latency", 32'(lat), 32'd32);
        alu_op("b2b.add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        check("b2b.hi", hi, 32'd0);
        check("b2b.lo", lo, 32'd15);
        @(posedge clk); #1;
        check("b2b.drop", 32'(valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_alu_muldiv.md
# mips_alu_muldiv

Parametrised WIDTH-bit execute-stage ALU for the pipelined MIPS-Lite CPU, replacing the chain of 1-bit ALU slices with a single block. Provides single-cycle AND/OR/ADD/SUB/SLT and iterative unsigned multiply and divide into HI/LO registers. A valid/ready handshake stalls the pipeline while a multi-cycle operation runs.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset; asynchronous assert, active-high.
- valid_in  input  1  an operation is presented on op/a/b.
- ready_out  output  1  block can accept; equals !busy.
- op  input  3  operation code:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
  - 011 MULTU, 100 DIVU
  - 101 reserved
- a, b  input  WIDTH  operands.
- result  output  WIDTH  registered result; for MULTU/DIVU equals new LO.
- zero  output  1  registered (result == 0).
- ovf  output  1  registered signed overflow; ADD/SUB only, else 0.
- valid_out  output  1  one-cycle pulse: result/zero/ovf are new.
- busy  output  1  MULTU/DIVU in progress.
- hi, lo  output  WIDTH  HI/LO architectural registers.

## Operation
- Accept: rising edge with valid_in && ready_out. valid_in while busy is ignored; the op is not queued and the upstream must hold it.
- AND/OR: bitwise.
- ADD/SUB: modulo 2^WIDTH.
  - ovf for ADD: operand signs equal and differ from the sum sign.
  - ovf for SUB: operand signs differ and the difference sign differs from a.
- SLT: result = 1 if a < b signed, else 0. Computed as sign(a−b) XOR sub-overflow, so it is correct at extremes.
- Reserved op 101: result 0, zero 1, ovf 0, valid_out pulses; hi/lo untouched.
- FSM states: IDLE, MUL, DIV.
- IDLE → MUL on MULTU accept. Load multiplicand = a, multiplier = b, 2·WIDTH-bit accumulator = 0, count = 0.
- MUL: per cycle, if multiplier LSB is 1, add the shifted multiplicand; then shift. Increment count.
  - On the WIDTH-th iteration: {hi,lo} ← full product; → IDLE.
- IDLE → DIV on DIVU accept. Restoring division, one quotient bit per cycle, MSB first, WIDTH iterations.
  - At completion: lo ← quotient, hi ← remainder; → IDLE.
- DIVU with b = 0: still takes WIDTH cycles; lo = all ones, hi = a. No flag is raised.
- Operand registers are captured at accept; a/b changes during MUL/DIV have no effect.
- hi/lo change only at MULTU/DIVU completion or reset.

## Timing
- Reset: all outputs 0 (result, zero, ovf, valid_out, busy, hi, lo), ready_out 1, state IDLE, count 0.
- Single-cycle ops: accept at edge N; result/zero/ovf/valid_out valid after edge N; valid_out drops after edge N+1 unless another op is accepted.
- MULTU/DIVU timing:
  - Accept at edge N; busy = 1 after edge N.
  - Iterations occur on edges N+1 … N+WIDTH.
  - After edge N+WIDTH: hi/lo/result/zero updated, valid_out = 1, busy = 0, ready_out = 1.
  - Latency is WIDTH cycles.
- Back-to-back: a new op may be accepted at the edge after the completion edge, i.e. the cycle where valid_out = 1. There are no dead cycles between ops.
- valid_out is 0 in every cycle while busy.
- rst asserted mid-operation: immediately aborts to IDLE, clears hi/lo and all outputs, no valid_out. After rst deasserts, the first edge may accept a new op.

## Test plan
- Reset then ALU ops (WIDTH=32):
  - ADD 0x7FFFFFFF + 1 → result 0x80000000, ovf 1, valid_out one cycle after accept.
  - SUB 5 − 5 → result 0, zero 1.
  - AND 0xF0F0 & 0x0FF0 → 0x00F0.
- SLT extremes:
  - a = 0x80000000, b = 1 → result 1.
  - a = 0x7FFFFFFF, b = 0xFFFFFFFF → result 0.
  - a = b → 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - hi = 0xFFFFFFFE, lo = 0x00000001.
  - valid_out exactly 32 cycles after accept; busy high for 32 cycles.
  - valid_in pulsed mid-run is ignored.
- DIVU 100 / 7 → lo 14, hi 2. DIVU 9 / 0 → lo 0xFFFFFFFF, hi 9. Each takes 32 cycles.
- Back-to-back: ADD accepted in the valid_out cycle of a MULTU → ADD result one cycle later; hi/lo keep the product.
- rst asserted 10 cycles into MULTU → busy 0, hi/lo 0, no valid_out. A following DIVU 8 / 2 completes normally with lo 4, hi 0.
